rotary_bcd_counter: RTL and testbench

//  Front end for the rotary-encoder display path: synchronises and debounces the

---
 rtl/rotary_bcd_counter.sv | 171 +++++++++++++++++
 tb/tb_rotary_bcd_counter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rotary_bcd_counter.sv
// -----------------------------------------------------------------------------
// rotary_bcd_counter
//
// Front end for the rotary-encoder display path. The encoder A/B pins and the
// push switch are synchronised and debounced. One step is taken per detent,
// and the design keeps a two-digit BCD position in the range 00..99. Pressing
// the push switch clears the position to 00.
//
// Parameters
//   DEBOUNCE_CYCLES : stable cycles needed before an input change is accepted (>=2)
//   DB_W            : debounce counter width (2**DB_W > DEBOUNCE_CYCLES)
//   WRAP            : 1 = wrap 99<->00, 0 = saturate at 99 and 00
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   enc_a      in   encoder channel A, asynchronous, idle high
//   enc_b      in   encoder channel B, asynchronous, idle high
//   enc_sw_n   in   encoder push switch, asynchronous, active low
//   bcd_tens   out  tens digit 0..9
//   bcd_ones   out  ones digit 0..9
//   step_valid out  one-cycle pulse per applied step (saturated no-ops included)
//   step_dir   out  direction of the last step, 1 = up (CW), 0 = down (CCW)
// -----------------------------------------------------------------------------
module rotary_bcd_counter #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DB_W            = 16,
    parameter int WRAP            = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       enc_sw_n,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       step_valid,
    output logic       step_dir
);

    // Bit positions of the three inputs inside the packed per-input vectors
    localparam int IDX_A  = 0;
    localparam int IDX_B  = 1;
    localparam int IDX_SW = 2;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_db;
    logic [DB_W-1:0] r_cnt [3];
    logic            r_a_q;
    logic            r_sw_q;

    logic [3:0]      r_tens;
    logic [3:0]      r_ones;
    logic            r_step_valid;
    logic            r_step_dir;

    logic            w_rise_a;
    logic            w_fall_sw;
    logic            w_up;
    logic [3:0]      w_next_tens;
    logic [3:0]      w_next_ones;

    // Two-flop synchronisers. Everything resets to the idle (high) level so that
    // releasing reset with the pins idle never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= {enc_sw_n, enc_b, enc_a};
            r_sync2 <= r_sync1;
        end
    end

    // Independent debouncers: a changed level must persist for DEBOUNCE_CYCLES
    // consecutive cycles; any return to the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db <= '1;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_db[i]  <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Delayed copies of the debounced A and switch levels for edge detection.
    // B only qualifies direction, so it needs no delayed copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_q  <= 1'b1;
            r_sw_q <= 1'b1;
        end else begin
            r_a_q  <= r_db[IDX_A];
            r_sw_q <= r_db[IDX_SW];
        end
    end

    assign w_rise_a  = r_db[IDX_A] & ~r_a_q;
    assign w_fall_sw = ~r_db[IDX_SW] & r_sw_q;
    assign w_up      = ~r_db[IDX_B];

    // Next BCD value for a step in the decoded direction. The end stops either
    // wrap around or hold, depending on WRAP; a held end stop is still a step.
    always_comb begin
        w_next_tens = r_tens;
        w_next_ones = r_ones;
        if (w_up) begin
            if (r_ones != 4'd9) begin
                w_next_ones = r_ones + 4'd1;
            end else if (r_tens != 4'd9) begin
                w_next_ones = 4'd0;
                w_next_tens = r_tens + 4'd1;
            end else if (WRAP != 0) begin
                w_next_ones = 4'd0;
                w_next_tens = 4'd0;
            end
        end else begin
            if (r_ones != 4'd0) begin
                w_next_ones = r_ones - 4'd1;
            end else if (r_tens != 4'd0) begin
                w_next_ones = 4'd9;
                w_next_tens = r_tens - 4'd1;
            end else if (WRAP != 0) begin
                w_next_ones = 4'd9;
                w_next_tens = 4'd9;
            end
        end
    end

    // Position register. A switch press in the same cycle as an A rise wins
    // and the step is dropped, so no step_valid pulse is produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tens       <= 4'd0;
            r_ones       <= 4'd0;
            r_step_valid <= 1'b0;
            r_step_dir   <= 1'b0;
        end else if (w_fall_sw) begin
            r_tens       <= 4'd0;
            r_ones       <= 4'd0;
            r_step_valid <= 1'b0;
        end else if (w_rise_a) begin
            r_tens       <= w_next_tens;
            r_ones       <= w_next_ones;
            r_step_valid <= 1'b1;
            r_step_dir   <= w_up;
        end else begin
            r_step_valid <= 1'b0;
        end
    end

    assign bcd_tens   = r_tens;
    assign bcd_ones   = r_ones;
    assign step_valid = r_step_valid;
    assign step_dir   = r_step_dir;

endmodule

// File: tb/tb_rotary_bcd_counter.sv
// -----------------------------------------------------------------------------
// tb_rotary_bcd_counter
//
// Drives one wrapping and one saturating instance from the same encoder pins
// (DEBOUNCE_CYCLES = 4) and compares positions, pulse counts and direction
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_rotary_bcd_counter;

    localparam int DBC = 4;
    localparam int DBW = 3;

    logic       clk;
    logic       rst_n;
    logic       encA;
    logic       encB;
    logic       encSw;

    logic [3:0] wrapTens;
    logic [3:0] wrapOnes;
    logic       wrapValid;
    logic       wrapDir;
    logic [3:0] satTens;
    logic [3:0] satOnes;
    logic       satValid;
    logic       satDir;

    int checks;
    int errors;
    int wrapPulses;
    int satPulses;
    int expPulses;

    typedef struct {
        logic       a;
        logic       b;
        logic       sw;
        int         cycles;
        logic [7:0] expWrap;
        logic [7:0] expSat;
        int         expPulses;
        logic       expDir;
    } vector_t;

    vector_t vecs [7];

    rotary_bcd_counter #(.DEBOUNCE_CYCLES(DBC), .DB_W(DBW), .WRAP(1)) uWrap (
        .clk(clk), .rst_n(rst_n), .enc_a(encA), .enc_b(encB), .enc_sw_n(encSw),
        .bcd_tens(wrapTens), .bcd_ones(wrapOnes),
        .step_valid(wrapValid), .step_dir(wrapDir)
    );

    rotary_bcd_counter #(.DEBOUNCE_CYCLES(DBC), .DB_W(DBW), .WRAP(0)) uSat (
        .clk(clk), .rst_n(rst_n), .enc_a(encA), .enc_b(encB), .enc_sw_n(encSw),
        .bcd_tens(satTens), .bcd_ones(satOnes),
        .step_valid(satValid), .step_dir(satDir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count step_valid pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (wrapValid) wrapPulses++;
        if (satValid)  satPulses++;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic [7:0] expW, input logic [7:0] expS,
                              input int expP, input logic expD);
        checkOutput({tag, "_wrapCount"}, int'({wrapTens, wrapOnes}), int'(expW));
        checkOutput({tag, "_satCount"}, int'({satTens, satOnes}), int'(expS));
        checkOutput({tag, "_wrapPulses"}, wrapPulses, expP);
        checkOutput({tag, "_satPulses"}, satPulses, expP);
        checkOutput({tag, "_wrapDir"}, int'(wrapDir), int'(expD));
        checkOutput({tag, "_satDir"}, int'(satDir), int'(expD));
    endtask

    task automatic applyStimulus(input logic a, input logic b, input logic sw, input int cycles);
        @(negedge clk);
        encA  = a;
        encB  = b;
        encSw = sw;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic stepUp();
        applyStimulus(1'b0, 1'b0, 1'b1, 10);
        applyStimulus(1'b1, 1'b0, 1'b1, 10);
        expPulses++;
    endtask

    task automatic stepDown();
        applyStimulus(1'b0, 1'b1, 1'b1, 10);
        applyStimulus(1'b1, 1'b1, 1'b1, 10);
        expPulses++;
    endtask

    task automatic pressSwitch();
        applyStimulus(encA, encB, 1'b0, 10);
        applyStimulus(encA, encB, 1'b1, 10);
    endtask

    initial begin
        int latency;
        bit found;

        checks     = 0;
        errors     = 0;
        wrapPulses = 0;
        satPulses  = 0;
        expPulses  = 0;

        // Count up from 00 to 03 with B low; B changing alone must not step
        vecs[0] = '{1'b1, 1'b0, 1'b1, 10, 8'h00, 8'h00, 0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 10, 8'h00, 8'h00, 0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 10, 8'h01, 8'h01, 1, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 10, 8'h01, 8'h01, 1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 10, 8'h02, 8'h02, 2, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 10, 8'h02, 8'h02, 2, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 10, 8'h03, 8'h03, 3, 1'b1};

        // Reset state, then idle pins after release must not step
        rst_n = 1'b0;
        encA  = 1'b1;
        encB  = 1'b1;
        encSw = 1'b1;
        repeat (3) @(negedge clk);
        checkState("reset", 8'h00, 8'h00, 0, 1'b0);
        checkOutput("reset_valid", int'(wrapValid), 0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkState("idle", 8'h00, 8'h00, 0, 1'b0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sw, vecs[i].cycles);
            checkState($sformatf("vec%0d", i), vecs[i].expWrap, vecs[i].expSat,
                       vecs[i].expPulses, vecs[i].expDir);
        end
        expPulses = 3;

        // Latency: the count changes on edge 6, edge 0 sampling the A rise
        applyStimulus(1'b0, 1'b0, 1'b1, 10);
        @(negedge clk);
        encA    = 1'b1;
        found   = 1'b0;
        latency = -1;
        for (int n = 0; n < 20 && !found; n++) begin
            @(posedge clk);
            #1;
            if ({wrapTens, wrapOnes} != 8'h03) begin
                found   = 1'b1;
                latency = n;
            end
        end
        checkOutput("latency", latency, 6);
        checkOutput("pulse_high", int'(wrapValid), 1);
        @(posedge clk);
        #1;
        checkOutput("pulse_low", int'(wrapValid), 0);
        repeat (10) @(posedge clk);
        #1;
        expPulses++;
        checkState("latency_done", 8'h04, 8'h04, expPulses, 1'b1);

        // Preload 99, then one more up-step hits the end stop
        for (int i = 0; i < 95; i++) stepUp();
        checkState("at99", 8'h99, 8'h99, expPulses, 1'b1);
        stepUp();
        checkState("up_from99", 8'h00, 8'h99, expPulses, 1'b1);

        // Clear leaves direction alone; down-step at 00 hits the lower stop
        pressSwitch();
        checkState("clear1", 8'h00, 8'h00, expPulses, 1'b1);
        stepDown();
        checkState("down_from00", 8'h99, 8'h00, expPulses, 1'b0);

        // Borrow across the tens digit: 10 -> 09
        pressSwitch();
        for (int i = 0; i < 10; i++) stepUp();
        checkState("at10", 8'h10, 8'h10, expPulses, 1'b1);
        stepDown();
        checkState("down_from10", 8'h09, 8'h09, expPulses, 1'b0);

        // Short A glitch must be filtered out
        @(negedge clk);
        encA = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        encA = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checkState("glitch", 8'h09, 8'h09, expPulses, 1'b0);

        // Switch press at 42 clears without a pulse
        pressSwitch();
        for (int i = 0; i < 42; i++) stepUp();
        checkState("at42", 8'h42, 8'h42, expPulses, 1'b1);
        pressSwitch();
        checkState("clear42", 8'h00, 8'h00, expPulses, 1'b1);
        checkOutput("clear42_valid", int'(wrapValid), 0);

        // Switch fall and A rise debounced in the same cycle: clear wins
        for (int i = 0; i < 5; i++) stepUp();
        applyStimulus(1'b0, 1'b0, 1'b1, 10);
        checkState("pre_align", 8'h05, 8'h05, expPulses, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 10);
        checkState("align", 8'h00, 8'h00, expPulses, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 10);

        // Reset in the middle of debouncing an A rise discards it
        for (int i = 0; i < 3; i++) stepUp();
        applyStimulus(1'b0, 1'b0, 1'b1, 10);
        checkState("pre_rst", 8'h03, 8'h03, expPulses, 1'b1);
        @(negedge clk);
        encA = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkState("mid_rst", 8'h00, 8'h00, expPulses, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkState("post_rst", 8'h00, 8'h00, expPulses, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
